seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed 6-digit seven-segment scan controller for the accelerometer wrapper display path.
- Drives the 3-bit select into the 6:1 digit mux and consumes its 4-bit nibble output.
- Registers and hex-decodes each nibble, then drives active-low anode, segment and decimal-point outputs.
- Each digit gets an anti-ghosting blank interval before its anode turns on.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range 4..2^CNT_W.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; legal range 1..REFRESH_DIV-2.
- CNT_W, 17: width of the slot counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low blanks the display and holds the scan at its start point.
- digit_in  in  4  nibble returned from the digit mux for the current sel.
- dp_mask  in  6  decimal point request per digit index; 1 = point on.
- sel  out  3  digit index to the mux; range 5..0 only.
- an  out  6  anode enables, active-low; an[i] corresponds to sel==i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at the end of each full 6-digit frame.

Behaviour:
- Reset (async, rst_n=0) sets: sel=5, slot counter=0, an=6'b111111, seg=7'b1111111, dp=1, frame_done=0, capture register=0.
- All outputs are registered. No combinational path from digit_in to seg.
- Scan order is descending: sel goes 5,4,3,2,1,0,5,...
- Slot counter runs 0..REFRESH_DIV-1 while en=1.
  - At terminal count it clears to 0.
  - sel decrements in the same cycle; when sel is 0 it wraps to 5.
- Blank phase (counter < BLANK_CYCLES): an=all 1s.
  - When counter == BLANK_CYCLES-1, capture digit_in together with dp_mask[sel].
  - The capture happens at least one cycle after the sel change, so the combinational mux has settled.
- Display phase (counter >= BLANK_CYCLES):
  - an[sel]=0, all other anode bits 1.
  - seg = hex decode of the captured nibble.
  - dp = ~captured dp bit.
  - seg and dp update in the cycle the counter reaches BLANK_CYCLES.
- Hex decode, shown active-high gfedcba (output is the inverse):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- frame_done=1 for exactly one cycle: when sel==0 and counter==REFRESH_DIV-1.
- Frame period is 6*REFRESH_DIV cycles.
- en deasserted mid-slot:
  - Next cycle: an=all 1s, seg=all 1s, dp=1, frame_done=0.
  - Counter is cleared to 0 and held; sel is forced to 5.
- en reasserted: scan restarts with a full blank phase on sel=5.
- dp_mask or digit_in changing during the display phase has no effect until the next capture.
- Reset mid-slot: outputs return to reset values immediately (asynchronous assertion). Scan restarts at sel=5, counter 0.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A leading flag sets to 1 at each frame start (sel=5 capture).
  - While the flag is 1 and the captured nibble is 0 for sel 5..1, that digit's anode stays off for the whole slot. Its dp still blanks it only if the dp bit is also 0.
  - The first nonzero nibble, or any captured dp bit of 1, clears the flag for the rest of the frame.
  - sel=0 is never blanked.
  - The flag also resets to 1 on rst_n and on en=0.
- Undefined: all six digits are always displayed, and the flag logic is absent.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset check: hold rst_n=0 for 3 cycles, then release with en=1 -> sel=5, an=111111, seg=1111111, dp=1. At cycle 2 after release, an=011111 (an[5]=0).
- Scan order and wrap: mux model returns nibble=sel, dp_mask=0 -> sel sequence 5,4,3,2,1,0,5, each held 8 cycles. Slot for sel=3 shows seg=~4F=0110000. frame_done pulses once every 48 cycles, on the last cycle of sel=0.
- Blank and latency: digit_in changes from 0x1 to 0xF at slot cycle 4 -> an is all 1s for cycles 0-1. seg holds ~06 until the next slot's capture. No glitch on an.
- Decimal point: dp_mask=6'b000100 -> dp=0 only during the display phase of sel=2; dp=1 in all other slots.
- en drop mid-slot: en=0 at cycle 5 of sel=3 -> next cycle all outputs are 1s and frame_done=0. After en=1, sel=5 with 2 blank cycles before an=011111.
- Leading zeros (macro defined): digits {5..0}=0,0,3,0,0,7 -> an stays 111111 during slots 5 and 4. Slots 3, 2, 1, 0 display "3","0","0","7". With dp_mask[5]=1, slot 5 displays "0." as well.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a 6-digit seven-segment display.
// The controller walks the external 6:1 digit mux with sel (5 down to 0).
// Each digit slot is REFRESH_DIV cycles long. The first BLANK_CYCLES cycles
// of a slot keep every anode off, which gives the mux time to settle and
// stops ghosting between neighbouring digits. On the last blank cycle the
// nibble and its decimal-point request are captured. From the next cycle
// the decoded pattern is driven with that digit's anode on.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (sel 5..1). A digit stays visible if its decimal point is on.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable; low blanks the display and parks the scan
//   digit_in    in   [3:0] nibble from the digit mux for the current sel
//   dp_mask     in   [5:0] decimal point request per digit (1 = point on)
//   sel         out  [2:0] digit index to the mux, 5..0
//   an          out  [5:0] anode enables, active-low, an[i] <-> sel==i
//   seg         out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
//   frame_done  out  one-cycle pulse on the last cycle of each 6-digit frame
//
// Handshake: none. digit_in is a plain combinational return for sel. It is
// sampled only on the last blank cycle of a slot, so it may change at any
// other time without visible effect.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_in,
    input  logic [5:0] dp_mask,
    output logic [2:0] sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]       SEL_FIRST  = 3'd5;

    // Hex to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] hi;
        case (nib)
            4'h0:    hi = 7'h3F;
            4'h1:    hi = 7'h06;
            4'h2:    hi = 7'h5B;
            4'h3:    hi = 7'h4F;
            4'h4:    hi = 7'h66;
            4'h5:    hi = 7'h6D;
            4'h6:    hi = 7'h7D;
            4'h7:    hi = 7'h07;
            4'h8:    hi = 7'h7F;
            4'h9:    hi = 7'h6F;
            4'hA:    hi = 7'h77;
            4'hB:    hi = 7'h7C;
            4'hC:    hi = 7'h39;
            4'hD:    hi = 7'h5E;
            4'hE:    hi = 7'h79;
            default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;
    logic [3:0]       nib_q, nib_d;
    logic             cap_dp_q, cap_dp_d;
    logic             capture;
    logic             hide_d;

    // Capture on the last blank cycle. sel has been stable since the slot
    // started, so the mux output has settled.
    assign capture = en && (cnt_q == BLANK_LAST);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // lead_q: still inside the leading-zero run of the current frame.
    // hide_q: the digit captured for the current slot is suppressed.
    logic lead_q, lead_d;
    logic hide_q;
    logic lead_now;

    always_comb begin
        lead_d   = lead_q;
        hide_d   = hide_q;
        lead_now = lead_q;
        if (!en) begin
            lead_d = 1'b1;
            hide_d = 1'b0;
        end else if (capture) begin
            // A new frame starts at the sel=5 capture.
            lead_now = (sel_q == SEL_FIRST) ? 1'b1 : lead_q;
            lead_d   = lead_now && (digit_in == 4'h0) && !dp_mask[sel_q];
            // The units digit always shows, even for a zero value.
            hide_d   = lead_d && (sel_q != 3'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lead_q <= 1'b1;
            hide_q <= 1'b0;
        end else begin
            lead_q <= lead_d;
            hide_q <= hide_d;
        end
    end
`else
    assign hide_d = 1'b0;
`endif

    // Every output register is computed from the next counter and sel
    // values. This keeps an, seg, dp and frame_done aligned with cnt_q and
    // sel_q in the same cycle.
    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        an_d         = 6'h3F;
        seg_d        = seg_q;
        dp_d         = 1'b1;
        frame_done_d = 1'b0;
        nib_d        = nib_q;
        cap_dp_d     = cap_dp_q;

        if (!en) begin
            cnt_d = '0;
            sel_d = SEL_FIRST;
            seg_d = 7'h7F;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                sel_d = (sel_q == 3'd0) ? SEL_FIRST : sel_q - 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (capture) begin
                nib_d    = digit_in;
                cap_dp_d = dp_mask[sel_q];
                seg_d    = hex7(digit_in);
            end

            // Display phase. seg holds its last value through the blank
            // phase because the anodes are off. dp is forced off there.
            if (cnt_d >= BLANK_END) begin
                dp_d = ~cap_dp_d;
                if (!hide_d) begin
                    an_d = ~(6'b000001 << sel_d);
                end
            end

            frame_done_d = (sel_d == 3'd0) && (cnt_d == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= SEL_FIRST;
            an_q         <= 6'h3F;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
            nib_q        <= 4'h0;
            cap_dp_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            nib_q        <= nib_d;
            cap_dp_q     <= cap_dp_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=8 and BLANK_CYCLES=2.
// A behavioural mux returns digits[sel]. Outputs are sampled on the falling
// edge. Cycle k means k rising edges after reset release. In cycle k the
// slot counter is k%8 and sel is 5-(k/8)%6.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int CW = 4;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] digit_in;
    logic [5:0] dp_mask;
    logic [2:0] sel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    logic [3:0] digits [6];

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digit_in  (digit_in),
        .dp_mask   (dp_mask),
        .sel       (sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    // ---- clock / mux model ----
    always #5 clk = ~clk;

    always_comb begin
        digit_in = (sel < 3'd6) ? digits[sel] : 4'h0;
    end

    // Active-low segment pattern taken from the decode table.
    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return ~t[n];
    endfunction

    function automatic logic [5:0] an_on(input int s);
        logic [5:0] v;
        v = 6'h3F;
        v[s] = 1'b0;
        return v;
    endfunction

    // ---- driver tasks ----
    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_digits_index();
        for (int i = 0; i < 6; i++) digits[i] = 4'(i);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        for (int i = 0; i < 6; i++) digits[i] = 4'h8;
        dp_mask = 6'h00;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (sel !== 3'd5) begin errors++; $display("FAIL reset_sel got %0d want 5", sel); end
        if (an !== 6'h3F) begin errors++; $display("FAIL reset_an got %b want 111111", an); end
        if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b want 1111111", seg); end
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
        rst_n = 1'b1;
        checks++;
        if (an !== 6'h3F) begin errors++; $display("FAIL rel_an_c0 got %b want 111111", an); end
        @(negedge clk);
        checks++;
        if (an !== 6'h3F) begin errors++; $display("FAIL rel_an_c1 got %b want 111111", an); end
        @(negedge clk);
        checks += 3;
        if (an !== 6'b011111) begin errors++; $display("FAIL rel_an_c2 got %b want 011111", an); end
        if (seg !== 7'b0000000) begin errors++; $display("FAIL rel_seg_c2 got %b want 0000000", seg); end
        if (dp !== 1'b1) begin errors++; $display("FAIL rel_dp_c2 got %b want 1", dp); end
        // Move into the sel=4 slot and assert reset between clock edges.
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (sel !== 3'd5) begin errors++; $display("FAIL async_sel got %0d want 5", sel); end
        if (an !== 6'h3F) begin errors++; $display("FAIL async_an got %b want 111111", an); end
        if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg got %b want 1111111", seg); end
        if (dp !== 1'b1) begin errors++; $display("FAIL async_dp got %b want 1", dp); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int cnt, s, fd_count;
        logic [6:0] hold;
        logic [5:0] ea;
        set_digits_index();
        dp_mask = 6'h00;
        do_reset();
        hold = 7'h7F;
        fd_count = 0;
        for (int k = 0; k < 96; k++) begin
            if (k > 0) @(negedge clk);
            cnt = k % RD;
            s   = 5 - ((k / RD) % 6);
            if (cnt == BC) hold = exp_seg(4'(s));
            ea = (cnt < BC) ? 6'h3F : an_on(s);
            checks += 4;
            if (sel !== 3'(s)) begin errors++; $display("FAIL scan_sel k=%0d got %0d want %0d", k, sel, s); end
            if (an !== ea) begin errors++; $display("FAIL scan_an k=%0d got %b want %b", k, an, ea); end
            if (seg !== hold) begin errors++; $display("FAIL scan_seg k=%0d got %b want %b", k, seg, hold); end
            if (frame_done !== (s == 0 && cnt == RD - 1)) begin
                errors++; $display("FAIL scan_fd k=%0d got %b", k, frame_done);
            end
            if (frame_done === 1'b1) fd_count++;
            if (s == 3 && cnt == 4) begin
                checks++;
                if (seg !== 7'b0110000) begin errors++; $display("FAIL scan_seg3 got %b want 0110000", seg); end
            end
        end
        checks++;
        if (fd_count != 2) begin errors++; $display("FAIL scan_fd_count got %0d want 2", fd_count); end
    endtask

    task automatic test_blank_latency();
        int cnt, s;
        logic [6:0] es;
        logic [5:0] ea;
        for (int i = 0; i < 6; i++) digits[i] = 4'h1;
        dp_mask = 6'h00;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            cnt = k % RD;
            s   = 5 - (k / RD);
            if (k == 4) for (int i = 0; i < 6; i++) digits[i] = 4'hF;
            if (k < BC) es = 7'h7F;
            else if (k < RD + BC) es = 7'b1111001;
            else es = 7'b0001110;
            ea = (cnt < BC) ? 6'h3F : an_on(s);
            checks += 2;
            if (seg !== es) begin errors++; $display("FAIL lat_seg k=%0d got %b want %b", k, seg, es); end
            if (an !== ea) begin errors++; $display("FAIL lat_an k=%0d got %b want %b", k, an, ea); end
        end
    endtask

    task automatic test_dp();
        int cnt, s;
        logic edp;
        set_digits_index();
        dp_mask = 6'b000100;
        do_reset();
        for (int k = 0; k < 48; k++) begin
            if (k > 0) @(negedge clk);
            cnt = k % RD;
            s   = 5 - (k / RD);
            edp = (s == 2 && cnt >= BC) ? 1'b0 : 1'b1;
            checks++;
            if (dp !== edp) begin errors++; $display("FAIL dp k=%0d got %b want %b", k, dp, edp); end
        end
    endtask

    task automatic test_en_drop();
        set_digits_index();
        dp_mask = 6'b001000;
        do_reset();
        repeat (21) @(negedge clk);   // sel=3, slot cycle 5
        checks += 2;
        if (an !== 6'b110111) begin errors++; $display("FAIL en_pre_an got %b want 110111", an); end
        if (dp !== 1'b0) begin errors++; $display("FAIL en_pre_dp got %b want 0", dp); end
        en = 1'b0;
        @(negedge clk);
        checks += 5;
        if (an !== 6'h3F) begin errors++; $display("FAIL en_off_an got %b want 111111", an); end
        if (seg !== 7'h7F) begin errors++; $display("FAIL en_off_seg got %b want 1111111", seg); end
        if (dp !== 1'b1) begin errors++; $display("FAIL en_off_dp got %b want 1", dp); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL en_off_fd got %b want 0", frame_done); end
        if (sel !== 3'd5) begin errors++; $display("FAIL en_off_sel got %0d want 5", sel); end
        repeat (3) @(negedge clk);
        checks += 2;
        if (sel !== 3'd5) begin errors++; $display("FAIL en_hold_sel got %0d want 5", sel); end
        if (an !== 6'h3F) begin errors++; $display("FAIL en_hold_an got %b want 111111", an); end
        en = 1'b1;
        checks++;
        if (an !== 6'h3F) begin errors++; $display("FAIL en_re_an0 got %b want 111111", an); end
        @(negedge clk);
        checks++;
        if (an !== 6'h3F) begin errors++; $display("FAIL en_re_an1 got %b want 111111", an); end
        @(negedge clk);
        checks += 3;
        if (an !== 6'b011111) begin errors++; $display("FAIL en_re_an2 got %b want 011111", an); end
        if (seg !== exp_seg(4'h5)) begin errors++; $display("FAIL en_re_seg got %b want %b", seg, exp_seg(4'h5)); end
        if (sel !== 3'd5) begin errors++; $display("FAIL en_re_sel got %0d want 5", sel); end
    endtask

    task automatic test_leading_zero();
        int s;
        logic [5:0] ea;
        digits[5] = 4'h0; digits[4] = 4'h0; digits[3] = 4'h3;
        digits[2] = 4'h0; digits[1] = 4'h0; digits[0] = 4'h7;
        dp_mask = 6'h00;
        do_reset();
        repeat (4) @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            if (j > 0) repeat (RD) @(negedge clk);
            s  = 5 - j;
            ea = (LZ && (s == 5 || s == 4)) ? 6'h3F : an_on(s);
            checks += 2;
            if (an !== ea) begin errors++; $display("FAIL lz_an s=%0d got %b want %b", s, an, ea); end
            if (seg !== exp_seg(digits[s])) begin
                errors++; $display("FAIL lz_seg s=%0d got %b want %b", s, seg, exp_seg(digits[s]));
            end
        end
        // A decimal point on sel=5 keeps that zero visible and ends the run.
        dp_mask = 6'b100000;
        do_reset();
        repeat (4) @(negedge clk);
        checks += 3;
        if (an !== 6'b011111) begin errors++; $display("FAIL lzdp_an5 got %b want 011111", an); end
        if (seg !== 7'b1000000) begin errors++; $display("FAIL lzdp_seg5 got %b want 1000000", seg); end
        if (dp !== 1'b0) begin errors++; $display("FAIL lzdp_dp5 got %b want 0", dp); end
        repeat (RD) @(negedge clk);
        checks++;
        if (an !== 6'b101111) begin errors++; $display("FAIL lzdp_an4 got %b want 101111", an); end
        // Next frame without the point: the run starts again at sel=5.
        dp_mask = 6'h00;
        repeat (5 * RD) @(negedge clk);
        ea = LZ ? 6'h3F : 6'b011111;
        checks++;
        if (an !== ea) begin errors++; $display("FAIL lz_frame2_an got %b want %b", an, ea); end
    endtask

    // ---- sequence and report ----
    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        dp_mask = 6'h00;
        for (int i = 0; i < 6; i++) digits[i] = 4'h0;
        test_reset();
        test_scan();
        test_blank_latency();
        test_dp();
        test_en_drop();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
